// File: rtl/demux1to2_pipe_pkg.sv
// Shared constants and types for the 1-to-2 stream demultiplexer.
package demux1to2_pipe_pkg;

    localparam int DEPTH = 2;

    typedef logic [1:0] count_t;

endpackage

// File: rtl/demux1to2_pipe_skid_buf2.sv
// Two-entry in-order buffer owned by one output channel of the demux.
// Head entry is presented on dout/valid; flush empties it without touching the stored data.
module skid_buf2
    import demux1to2_pipe_pkg::*;
#(
    parameter int size = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            push,
    input  logic [size-1:0] din,
    output logic            full,
    input  logic            pop,
    output logic [size-1:0] dout,
    output logic            valid
);

    logic [size-1:0] mem_q [DEPTH];
    count_t          count_q, count_d;
    logic            rdPtr_q, rdPtr_d;
    logic            wrPtr_q, wrPtr_d;
    logic            doPush;
    logic            doPop;

    // Qualify the requests so a push into a full buffer or a pop from an empty one is ignored.
    always_comb begin
        doPush = push & (count_q != count_t'(DEPTH));
        doPop  = pop & (count_q != '0);
    end

    // Next occupancy and pointers; flush clears them and overrides any push or pop.
    always_comb begin
        count_d = count_q;
        rdPtr_d = rdPtr_q;
        wrPtr_d = wrPtr_q;
        if (flush_i) begin
            count_d = '0;
            rdPtr_d = 1'b0;
            wrPtr_d = 1'b0;
        end else begin
            if (doPush) begin
                wrPtr_d = ~wrPtr_q;
            end
            if (doPop) begin
                rdPtr_d = ~rdPtr_q;
            end
            case ({doPush, doPop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // Occupancy and pointer registers, emptied immediately by reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count_q <= '0;
            rdPtr_q <= 1'b0;
            wrPtr_q <= 1'b0;
        end else begin
            count_q <= count_d;
            rdPtr_q <= rdPtr_d;
            wrPtr_q <= wrPtr_d;
        end
    end

    // Data storage has no reset; its contents only matter while the count marks them valid.
    always_ff @(posedge clk_i) begin
        if (doPush && !flush_i) begin
            mem_q[wrPtr_q] <= din;
        end
    end

    // Head entry presentation; data reads as zero while the buffer is empty.
    always_comb begin
        valid = (count_q != '0);
        full  = (count_q == count_t'(DEPTH));
        dout  = valid ? mem_q[rdPtr_q] : '0;
    end

endmodule

// File: rtl/demux1to2_pipe.sv
// Splits one valid/ready stream into two independently buffered channels chosen per beat by select_i.
// Each channel has its own two-entry buffer so a stalled consumer never blocks the other channel.
module demux1to2_pipe
    import demux1to2_pipe_pkg::*;
#(
    parameter int size = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic [size-1:0] data_i,
    input  logic            select_i,
    input  logic            valid_i,
    output logic            ready_o,
    output logic [size-1:0] data0_o,
    output logic            valid0_o,
    input  logic            ready0_i,
    output logic [size-1:0] data1_o,
    output logic            valid1_o,
    input  logic            ready1_i
);

    logic full0, full1;
    logic push0, push1;
    logic pop0, pop1;

    // Accept only when out of reset, not flushing, and the selected channel has room.
    // A pop in the same cycle does not open space early, so there is no ready path from the consumers.
    always_comb begin
        ready_o = rst_i & ~flush_i & ~(select_i ? full1 : full0);
    end

    // Steer an accepted beat to the selected channel and form each channel's pop handshake.
    always_comb begin
        push0 = valid_i & ready_o & ~select_i;
        push1 = valid_i & ready_o &  select_i;
        pop0  = valid0_o & ready0_i;
        pop1  = valid1_o & ready1_i;
    end

    skid_buf2 #(.size(size)) u_chan0 (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .push    (push0),
        .din     (data_i),
        .full    (full0),
        .pop     (pop0),
        .dout    (data0_o),
        .valid   (valid0_o)
    );

    skid_buf2 #(.size(size)) u_chan1 (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .push    (push1),
        .din     (data_i),
        .full    (full1),
        .pop     (pop1),
        .dout    (data1_o),
        .valid   (valid1_o)
    );

endmodule
